// File: rtl/adc_tx_pkg.sv
// Shared constants and state encoding for the two-lane ADC transmit serializer.
package adc_tx_pkg;
  localparam int SLOT_W   = 3;
  localparam int SLOT_CNT = 8;
  localparam int LANE_CNT = 2;
  localparam int WORD_W   = 16;

  localparam logic [SLOT_W-1:0] SLOT_LAST = 3'(SLOT_CNT - 1);
  localparam logic [WORD_W-1:0] RAMP_STEP = 16'd4;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;
endpackage

// File: rtl/adc_tx_ramp_gen.sv
// Ramp test-pattern source; only built when ADC_TX_RAMP_EN is defined.
module adc_tx_ramp_gen
  import adc_tx_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ramp_mode,
  input  logic              load_en,
  output logic [WORD_W-1:0] ramp_word
);
  logic              mode_q, mode_d;
  logic [WORD_W-1:0] cnt_q, cnt_d;
  logic              restart;

  // A rising ramp_mode restarts at 0 even if that same edge loads a word.
  always_comb begin
    restart   = ramp_mode && !mode_q;
    mode_d    = ramp_mode;
    ramp_word = restart ? '0 : cnt_q;
    cnt_d     = restart ? '0 : cnt_q;
    if (load_en) cnt_d = ramp_word + RAMP_STEP;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      mode_q <= mode_d;
      cnt_q  <= cnt_d;
    end
  end
endmodule

// File: rtl/adc_lane_serializer.sv
// Two-lane ADC-format serializer: 16-bit words out MSB first over 8 slots with a frame marker.
// Optional ramp test source is enabled with the ADC_TX_RAMP_EN macro.
//
// state | meaning
// IDLE  | lanes and frame low, waiting for en at a word boundary
// RUN   | presenting slots 0..7 of the loaded word
module adc_lane_serializer
  import adc_tx_pkg::*;
#(
  parameter logic [WORD_W-1:0] IDLE_WORD = 16'h0000,
  parameter bit                PAD_LSB   = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
`ifdef ADC_TX_RAMP_EN
  input  logic                ramp_mode,
`endif
  input  logic [WORD_W-1:0]   s_data,
  input  logic                s_valid,
  output logic                s_ready,
  output logic [LANE_CNT-1:0] lane_dout,
  output logic                frame_out,
  output logic                underflow,
  output logic [15:0]         underflow_cnt
);
  state_e              state_q, state_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic [WORD_W-1:0]   shreg_q, shreg_d;
  logic [LANE_CNT-1:0] lane_q, lane_d;
  logic                frame_q, frame_d;
  logic                underflow_q, underflow_d;
  logic [15:0]         underflow_cnt_q, underflow_cnt_d;

  logic                boundary, load, ramp_sel;
  logic [WORD_W-1:0]   load_word, ramp_word;

`ifdef ADC_TX_RAMP_EN
  assign ramp_sel = ramp_mode;
  adc_tx_ramp_gen u_ramp (
    .clk       (clk),
    .rst_n     (rst_n),
    .ramp_mode (ramp_mode),
    .load_en   (load && ramp_sel),
    .ramp_word (ramp_word)
  );
`else
  assign ramp_sel  = 1'b0;
  assign ramp_word = '0;
`endif

  always_comb begin
    boundary = (state_q == IDLE && en) || (state_q == RUN && slot_q == SLOT_LAST);
    load     = boundary && en;
    // rst_n gating keeps s_ready low while reset is held even though en may be high.
    s_ready  = rst_n && load && !ramp_sel;

    load_word = ramp_sel ? ramp_word : (s_valid ? s_data : IDLE_WORD);
    if (PAD_LSB) load_word[1:0] = 2'b00;
    underflow_d = load && !ramp_sel && !s_valid;

    state_d = state_q;
    slot_d  = slot_q;
    shreg_d = shreg_q;
    lane_d  = '0;
    frame_d = 1'b0;
    if (load) begin
      state_d = RUN;
      slot_d  = '0;
      shreg_d = {load_word[WORD_W-3:0], 2'b00};
      lane_d  = {load_word[WORD_W-2], load_word[WORD_W-1]};
      frame_d = 1'b1;
    end else if (boundary) begin
      state_d = IDLE;
      slot_d  = '0;
      shreg_d = '0;
    end else if (state_q == RUN) begin
      slot_d  = slot_q + 3'd1;
      shreg_d = {shreg_q[WORD_W-3:0], 2'b00};
      lane_d  = {shreg_q[WORD_W-2], shreg_q[WORD_W-1]};
      frame_d = !slot_d[SLOT_W-1];
    end

    underflow_cnt_d = underflow_cnt_q;
    if (underflow_d && underflow_cnt_q != 16'hFFFF) underflow_cnt_d = underflow_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      slot_q          <= '0;
      shreg_q         <= '0;
      lane_q          <= '0;
      frame_q         <= 1'b0;
      underflow_q     <= 1'b0;
      underflow_cnt_q <= '0;
    end else begin
      state_q         <= state_d;
      slot_q          <= slot_d;
      shreg_q         <= shreg_d;
      lane_q          <= lane_d;
      frame_q         <= frame_d;
      underflow_q     <= underflow_d;
      underflow_cnt_q <= underflow_cnt_d;
    end
  end

  assign lane_dout     = lane_q;
  assign frame_out     = frame_q;
  assign underflow     = underflow_q;
  assign underflow_cnt = underflow_cnt_q;
endmodule

// File: tb/tb_adc_lane_serializer.sv
// Self-checking bench for adc_lane_serializer against a word/slot-level reference model.
module tb_adc_lane_serializer;
  localparam logic [15:0] IDLE_W = 16'h0000;
  localparam bit          PAD    = 1'b1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [15:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [1:0]  lane_dout;
  logic        frame_out;
  logic        underflow;
  logic [15:0] underflow_cnt;
  logic        rmode = 1'b0;

  int checks = 0;
  int failures = 0;

  // Reference model: position within the current word (-1 when idle) and the word itself.
  int          m_pos = -1;
  logic [15:0] m_word = '0;
  int          m_cnt = 0;
  logic        m_uf = 1'b0;
  logic [15:0] m_ramp = '0;
  logic        m_rprev = 1'b0;
  logic        rdy_seen;

  always #5 clk = ~clk;

`ifdef ADC_TX_RAMP_EN
  logic ramp_mode;
  assign ramp_mode = rmode;
`endif

  adc_lane_serializer #(.IDLE_WORD(IDLE_W), .PAD_LSB(PAD)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .en            (en),
`ifdef ADC_TX_RAMP_EN
    .ramp_mode     (ramp_mode),
`endif
    .s_data        (s_data),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .lane_dout     (lane_dout),
    .frame_out     (frame_out),
    .underflow     (underflow),
    .underflow_cnt (underflow_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] exp_lanes();
    logic [1:0] l;
    l = 2'b00;
    if (m_pos >= 0) begin
      l[0] = m_word[15 - 2*m_pos];
      l[1] = m_word[14 - 2*m_pos];
    end
    return l;
  endfunction

  task automatic model_step(input logic bnd);
    logic [15:0] w;
    m_uf = 1'b0;
    if (rmode && !m_rprev) m_ramp = 16'h0000;
    if (bnd && en) begin
      if (rmode) begin
        w = m_ramp;
        m_ramp = m_ramp + 16'd4;
      end else if (s_valid) begin
        w = s_data;
      end else begin
        w = IDLE_W;
        m_uf = 1'b1;
        if (m_cnt < 65535) m_cnt++;
      end
      if (PAD) w = w & 16'hFFFC;
      m_word = w;
      m_pos = 0;
    end else if (bnd) begin
      m_pos = -1;
    end else if (m_pos >= 0) begin
      m_pos++;
    end
    m_rprev = rmode;
  endtask

  task automatic check_outputs();
    chk("lane_dout", 32'(lane_dout), 32'(exp_lanes()));
    chk("frame_out", 32'(frame_out), 32'(m_pos >= 0 && m_pos < 4));
    chk("underflow", 32'(underflow), 32'(m_uf));
    chk("underflow_cnt", 32'(underflow_cnt), 32'(m_cnt));
  endtask

  // Called at a negedge with inputs already driven; returns at the next negedge.
  task automatic cycle();
    logic bnd;
    #1;
    bnd = (m_pos < 0 && en) || (m_pos == 7);
    rdy_seen = s_ready;
    chk("s_ready", 32'(s_ready), 32'(en && bnd && !rmode));
    @(posedge clk);
    model_step(bnd);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_lane", 32'(lane_dout), 32'd0);
    chk("rst_frame", 32'(frame_out), 32'd0);
    chk("rst_uf", 32'(underflow), 32'd0);
    chk("rst_cnt", 32'(underflow_cnt), 32'd0);
    chk("rst_ready", 32'(s_ready), 32'd0);
    m_pos = -1; m_cnt = 0; m_uf = 1'b0; m_ramp = '0; m_rprev = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] e0, e1, ef;
    int last, nrdy, nuf;
    e0 = 8'b11001000;
    e1 = 8'b00111010;
    ef = 8'b11110000;
    @(negedge clk);
    do_reset();

    // Directed A5C4 pattern.
    en = 1'b1; s_valid = 1'b1; s_data = 16'hA5C4;
    for (int k = 0; k < 8; k++) begin
      cycle();
      chk("a5c4_lane0", 32'(lane_dout[0]), 32'(e0[7-k]));
      chk("a5c4_lane1", 32'(lane_dout[1]), 32'(e1[7-k]));
      chk("a5c4_frame", 32'(frame_out), 32'(ef[7-k]));
    end

    // Back-to-back words with ready spacing.
    do_reset();
    en = 1'b1; s_valid = 1'b1; s_data = 16'h1234;
    last = -1; nrdy = 0;
    for (int i = 0; i < 24; i++) begin
      cycle();
      if (i == 0) s_data = 16'hFFFF;
      if (rdy_seen) begin
        if (last >= 0) chk("rdy_gap", 32'(i - last), 32'd8);
        last = i;
        nrdy++;
      end
      if (i == 15) chk("ffff_slot7", 32'(lane_dout), 32'd0);
    end
    chk("rdy_count", 32'(nrdy), 32'd3);

    // Three underflow words.
    do_reset();
    en = 1'b1; s_valid = 1'b0; nuf = 0;
    for (int i = 0; i < 24; i++) begin
      cycle();
      if (underflow) nuf++;
    end
    chk("uf_pulses", 32'(nuf), 32'd3);
    chk("uf_cnt3", 32'(underflow_cnt), 32'd3);
    en = 1'b0;
    for (int i = 0; i < 3; i++) cycle();

    // Counter saturation from a preloaded value while idle.
    force dut.underflow_cnt_q = 16'hFFFD;
    @(posedge clk);
    @(negedge clk);
    release dut.underflow_cnt_q;
    m_cnt = 32'hFFFD;
    chk("cnt_preload", 32'(underflow_cnt), 32'hFFFD);
    en = 1'b1; s_valid = 1'b0;
    for (int i = 0; i < 32; i++) cycle();
    chk("cnt_saturate", 32'(underflow_cnt), 32'hFFFF);

    // en dropped at slot 2: word completes, then idle.
    do_reset();
    en = 1'b1; s_valid = 1'b1; s_data = 16'hBEEF;
    for (int i = 0; i < 3; i++) cycle();
    en = 1'b0;
    for (int i = 0; i < 5; i++) cycle();
    chk("drop_frame_s7", 32'(frame_out), 32'd0);
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("drop_idle_lane", 32'(lane_dout), 32'd0);
      chk("drop_idle_ready", 32'(rdy_seen), 32'd0);
    end

    // Reset asserted at slot 5, then a fresh word.
    en = 1'b1; s_valid = 1'b1; s_data = 16'h5A3C;
    for (int i = 0; i < 6; i++) cycle();
    do_reset();
    s_data = 16'hC3F0;
    cycle();
    chk("post_rst_frame", 32'(frame_out), 32'd1);
    chk("post_rst_lane", 32'(lane_dout), 32'b11);

    // Randomized traffic with occasional mid-word resets.
    for (int i = 0; i < 600; i++) begin
      en = ($urandom % 8) != 0;
      s_valid = ($urandom % 4) != 0;
      s_data = 16'($urandom);
      if (($urandom % 150) == 0) do_reset();
      cycle();
    end

`ifdef ADC_TX_RAMP_EN
    do_reset();
    en = 1'b1; s_valid = 1'b1; rmode = 1'b1;
    for (int i = 0; i < 48; i++) begin
      s_data = 16'($urandom);
      cycle();
    end
    rmode = 1'b0;
    for (int i = 0; i < 16; i++) cycle();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/adc_lane_serializer.md
# adc_lane_serializer

Transmit-side counterpart of the two-lane ADC data receiver. It takes 16-bit parallel samples over a valid/ready stream and emits them as two interleaved serial lanes plus a frame marker, in the format the ADC itself produces. Bench loopback and on-board receiver alignment tests use it to drive the data PHY. It is pure RTL, one bit per lane per clock; OSERDES/ODDR wrapping happens outside this block.

## Interface
- IDLE_WORD, 16'h0000, word sent when no sample is available at a word boundary
- PAD_LSB, 1, when 1, bits [1:0] of every transmitted word are forced to 0, matching the ADC's two zero LSBs
- clk  in  1  serial bit clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  transmit enable; sampled only at word boundaries
- s_data  in  16  sample to transmit
- s_valid  in  1  s_data valid
- s_ready  out  1  sample accepted on a clock edge where s_valid && s_ready
- lane_dout  out  2  serial lanes; [0] carries the odd bits, [1] carries the even bits
- frame_out  out  1  high for slots 0-3 and low for slots 4-7 of each word
- underflow  out  1  one-cycle pulse when IDLE_WORD is substituted
- underflow_cnt  out  16  saturating underflow count

## Operation
- States:
  - IDLE: outputs low.
  - RUN: a 3-bit slot counter runs 0..7.
- Boundary condition: (IDLE && en) || (RUN && slot==7).
- At a boundary:
  - If en is high:
    - Load s_data if s_valid, otherwise load IDLE_WORD and assert the underflow pulse.
    - slot<=0, state<=RUN.
  - If en is low: state<=IDLE.
- s_ready = en && boundary. s_ready is combinational from registered state and en; it never depends on s_valid.
- Lane mapping, MSB first:
  - lane_dout[0] = word[15-2*slot]
  - lane_dout[1] = word[14-2*slot]
  - Slot 7 therefore carries bits 1 and 0.
- PAD_LSB is applied at load time and also applies to IDLE_WORD.
- underflow_cnt increments on each underflow pulse and holds at 16'hFFFF. Only reset clears it.
- Deasserting en mid-word does not truncate the word. The current word completes, then the block enters IDLE.
- When s_valid and an underflow condition would coincide, data wins: underflow is raised only if s_valid is low.

## Timing
- Reset values: lane_dout=0, frame_out=0, underflow=0, underflow_cnt=0, s_ready=0, state=IDLE, slot=0.
- All outputs are registered, except s_ready.
- Word accepted at edge t: lanes and frame_out show slot 0 after edge t, and slot k after edge t+k.
- Throughput is one word per 8 clocks with no bubbles. The next word loads at the same edge on which slot 7 is presented.
- frame_out is a 50% duty marker with period 8 clocks, rising at slot 0.
- Reset asserted mid-word: all outputs clear immediately (asynchronously). After release, the first word starts at slot 0.

## Configuration
- ADC_TX_RAMP_EN defined:
  - Adds input ramp_mode (1 bit).
  - While ramp_mode=1:
    - s_ready is held 0 and s_data is ignored.
    - Each boundary loads a ramp counter instead.
    - The ramp counter starts at 0 on entry, steps by 4 each word, and wraps 16'hFFFC→0.
    - No underflow is generated.
  - ramp_mode is sampled at boundaries only.
- ADC_TX_RAMP_EN undefined: no ramp_mode port and no ramp logic.

## Structure
- Package adc_tx_pkg holds:
  - slot width and count constants (3, 8)
  - lane count (2)
  - state enum (IDLE, RUN)
  - RAMP_STEP=4
- Optional sub-module adc_tx_ramp_gen, present only under ADC_TX_RAMP_EN:
  - 16-bit counter with a load-enable at the boundary.
  - Synchronous restart when ramp_mode rises.

## Test plan
- Reset, en=1, s_data=16'hA5C4 with s_valid held 1 → over slots 0-7:
  - lane_dout[0] = 1,1,0,0,1,0,0,0
  - lane_dout[1] = 0,0,1,1,1,0,1,0
  - frame_out = 1,1,1,1,0,0,0,0
- Back-to-back words 16'h1234 then 16'hFFFF with PAD_LSB=1:
  - s_ready pulses exactly every 8 clocks.
  - Second word slot 7 drives lanes = 2'b00.
- en=1 with s_valid=0 for 3 words:
  - IDLE_WORD is sent each time.
  - underflow pulses 3 times and underflow_cnt=3.
  - Preload the counter to 16'hFFFF via a forced-state test and check it saturates.
- en dropped at slot 2 → the word completes through slot 7, then lanes and frame_out go to 0 and s_ready stays 0.
- rst_n asserted at slot 5 → outputs are 0 in the same cycle. After release, a fresh word starts at slot 0.
- With ADC_TX_RAMP_EN and ramp_mode=1 → words are 0, 4, 8, …; after 16'hFFFC the next word is 0; s_ready stays 0.
